product_bcd_display: RTL and testbench

Downstream consumer of the sequential 8x8 multiplier. Captures the 16-bit product when the multiplier's done rises and converts it to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine, one iteration per clock. Holds the result and drives a time-multiplexed 5-digit seven-segment display.

---
 rtl/product_bcd_display_if.sv | 29 ++
 rtl/product_bcd_display.sv | 169 ++++++++++++++++
 tb/tb_product_bcd_display.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/product_bcd_display_if.sv
// Handshake bus between the 8x8 multiplier (master) and the product BCD display (slave).
// prod_valid is a level; a rising edge requests one conversion. bcd_valid pulses for one
// cycle when bcd_out takes a new value; busy is high while a conversion is in flight.
interface product_bcd_display_if;
    logic [15:0] product_in;
    logic        prod_valid;
    logic        busy;
    logic        bcd_valid;
    logic [19:0] bcd_out;
    logic [1:0]  state_dbg;

    modport master (
        output product_in,
        output prod_valid,
        input  busy,
        input  bcd_valid,
        input  bcd_out,
        input  state_dbg
    );

    modport slave (
        input  product_in,
        input  prod_valid,
        output busy,
        output bcd_valid,
        output bcd_out,
        output state_dbg
    );
endinterface

// File: rtl/product_bcd_display.sv
// Captures a 16-bit product, converts it to 5 BCD digits with a sequential double-dabble
// engine, and scans the held result onto a 5-digit seven-segment display. Optional macro: BLANK_LZ_EN.
module product_bcd_display #(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 4
) (
    input  logic                        clk,
    input  logic                        reset_a,
    product_bcd_display_if.slave        bus,
    output logic [4:0]                  digit_en,
    output logic                        seg_a,
    output logic                        seg_b,
    output logic                        seg_c,
    output logic                        seg_d,
    output logic                        seg_e,
    output logic                        seg_f,
    output logic                        seg_g
);

    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = WIDTH + BCD_W;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_next;
    logic [CNT_W-1:0]   count;
    logic               prev_valid;
    logic               start_evt;
    logic               busy_r;
    logic               bcd_valid_r;
    logic [BCD_W-1:0]   bcd_r;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit_idx;
    logic [3:0]         nib;
    logic               blank;
    logic [6:0]         seg_pat;
    logic [6:0]         segs;

    assign start_evt     = bus.prod_valid & ~prev_valid;
    assign bus.busy      = busy_r;
    assign bus.bcd_valid = bcd_valid_r;
    assign bus.bcd_out   = bcd_r;
    assign bus.state_dbg = state;

    // One double-dabble step: correct every BCD nibble >= 5, then shift the whole register.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH + 4*i +: 4] >= 4'd5) begin
                sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        sr_next = sr_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= IDLE;
            sr          <= '0;
            count       <= '0;
            prev_valid  <= 1'b0;
            busy_r      <= 1'b0;
            bcd_valid_r <= 1'b0;
            bcd_r       <= '0;
        end else begin
            prev_valid  <= bus.prod_valid;
            bcd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        sr     <= {{BCD_W{1'b0}}, bus.product_in};
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Requests arriving here are dropped; there is no queue.
                    sr    <= sr_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        bcd_r       <= sr_next[SR_W-1:WIDTH];
                        bcd_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan, independent of the conversion engine.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            digit_en  <= 5'b00001;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd4) ? 3'd0 : digit_idx + 3'd1;
            digit_en  <= {digit_en[3:0], digit_en[4]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        nib = 4'd0;
        case (digit_idx)
            3'd0:    nib = bcd_r[3:0];
            3'd1:    nib = bcd_r[7:4];
            3'd2:    nib = bcd_r[11:8];
            3'd3:    nib = bcd_r[15:12];
            3'd4:    nib = bcd_r[19:16];
            default: nib = 4'd0;
        endcase
    end

`ifdef BLANK_LZ_EN
    // A digit is blanked when it and every more significant digit are zero; ones never is.
    always_comb begin
        blank = 1'b0;
        case (digit_idx)
            3'd1:    blank = (bcd_r[19:4]  == 16'd0);
            3'd2:    blank = (bcd_r[19:8]  == 12'd0);
            3'd3:    blank = (bcd_r[19:12] == 8'd0);
            3'd4:    blank = (bcd_r[19:16] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_pat = 7'b0000000;
        case (nib)
            4'd0:    seg_pat = 7'b1111110;
            4'd1:    seg_pat = 7'b0110000;
            4'd2:    seg_pat = 7'b1101101;
            4'd3:    seg_pat = 7'b1111001;
            4'd4:    seg_pat = 7'b0110011;
            4'd5:    seg_pat = 7'b1011011;
            4'd6:    seg_pat = 7'b1011111;
            4'd7:    seg_pat = 7'b1110000;
            4'd8:    seg_pat = 7'b1111111;
            4'd9:    seg_pat = 7'b1111011;
            default: seg_pat = 7'b0000000;
        endcase
    end

    assign segs = blank ? 7'b0000000 : seg_pat;
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = segs;

endmodule

// File: tb/tb_product_bcd_display.sv
// Bench for product_bcd_display: directed and random products checked every cycle against
// an arithmetic reference model, plus a scoreboard of expected BCD results.
module tb_product_bcd_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       reset_a;
    logic [4:0] digit_en;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    product_bcd_display_if bus ();

    product_bcd_display #(.WIDTH(16), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset_a  (reset_a),
        .bus      (bus.slave),
        .digit_en (digit_en),
        .seg_a    (seg_a),
        .seg_b    (seg_b),
        .seg_c    (seg_c),
        .seg_d    (seg_d),
        .seg_e    (seg_e),
        .seg_f    (seg_f),
        .seg_g    (seg_g)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tbl [0:9];
    initial begin
        seg_tbl[0] = 7'b1111110; seg_tbl[1] = 7'b0110000; seg_tbl[2] = 7'b1101101;
        seg_tbl[3] = 7'b1111001; seg_tbl[4] = 7'b0110011; seg_tbl[5] = 7'b1011011;
        seg_tbl[6] = 7'b1011111; seg_tbl[7] = 7'b1110000; seg_tbl[8] = 7'b1111111;
        seg_tbl[9] = 7'b1111011;
    end

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        for (int d = 0; d < 5; d++) r[4*d +: 4] = 4'((v / pow10(d)) % 10);
        return r;
    endfunction

    // ---------------- reference model ----------------
    bit          m_init = 1'b0;
    bit          m_busy, m_valid, m_prev;
    int          m_left, m_cap, m_num, cyc, cap_cyc;
    logic [19:0] exp_q[$];

    always @(posedge clk) begin
        if (reset_a) begin
            m_busy = 0; m_valid = 0; m_prev = 0; m_left = 0;
            m_num = 0; cyc = 0; m_init = 1;
            exp_q.delete();
        end else begin
            cyc++;
            m_valid = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_num   = m_cap;
                    m_valid = 1;
                    m_busy  = 0;
                end
            end else if (bus.prod_valid && !m_prev) begin
                m_cap   = int'(bus.product_in);
                m_busy  = 1;
                m_left  = 16;
                cap_cyc = cyc;
                exp_q.push_back(to_bcd(int'(bus.product_in)));
            end
            m_prev = bus.prod_valid;
        end
    end

    // Per-cycle comparison of handshake and display against the model.
    always @(negedge clk) begin
        if (m_init) begin
            int idx, dig;
            logic [6:0] exp_seg;
            logic [19:0] e;
            idx = (cyc / SCAN_DIV) % 5;
            dig = (m_num / pow10(idx)) % 10;
            exp_seg = seg_tbl[dig];
`ifdef BLANK_LZ_EN
            if (idx > 0 && m_num < pow10(idx)) exp_seg = 7'b0000000;
`endif
            check("busy",      32'(bus.busy),      32'(m_busy));
            check("bcd_valid", 32'(bus.bcd_valid), 32'(m_valid));
            check("bcd_out",   32'(bus.bcd_out),   32'(to_bcd(m_num)));
            check("digit_en",  32'(digit_en),      32'(5'b00001 << idx));
            check("segments",  32'({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}), 32'(exp_seg));
            if (bus.bcd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_bcd",  32'(bus.bcd_out), 32'(e));
                    check("latency", 32'(cyc - cap_cyc), 32'd16);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        tick(1);
        while (bus.busy === 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        check("done_in_time", 32'(bus.busy), 32'd0);
    endtask

    task automatic convert(input logic [15:0] v, input int hold, input int gap);
        bus.product_in = v;
        bus.prod_valid = 1'b1;
        tick(hold);
        bus.prod_valid = 1'b0;
        wait_idle();
        tick(gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_a        = 1'b1;
        bus.product_in = '0;
        bus.prod_valid = 1'b0;
        tick(2);
        reset_a = 1'b0;
        check("reset_bcd_out",  32'(bus.bcd_out), 32'd0);
        check("reset_digit_en", 32'(digit_en), 32'b00001);
        tick(25);

        convert(16'd7839, 2, 25);
        check("dir_7839", 32'(bus.bcd_out), 32'h07839);
        convert(16'd65025, 1, 22);
        convert(16'd0, 3, 22);
        check("dir_zero", 32'(bus.bcd_out), 32'h00000);
        convert(16'd65535, 1, 22);
        check("dir_max", 32'(bus.bcd_out), 32'h65535);
        convert(16'd10, 1, 22);
        convert(16'd99, 1, 22);

        // Second rising edge mid-conversion is ignored; level held past completion starts nothing.
        bus.product_in = 16'd7839;
        bus.prod_valid = 1'b1;
        tick(1);
        bus.prod_valid = 1'b0;
        tick(4);
        bus.product_in = 16'd1234;
        bus.prod_valid = 1'b1;
        tick(20);
        bus.prod_valid = 1'b0;
        wait_idle();
        check("ignored_restart", 32'(bus.bcd_out), 32'h07839);
        tick(10);

        // Reset lands on the eighth shift edge of a conversion.
        bus.product_in = 16'd4321;
        bus.prod_valid = 1'b1;
        tick(1);
        bus.prod_valid = 1'b0;
        tick(7);
        reset_a = 1'b1;
        tick(1);
        reset_a = 1'b0;
        check("abort_busy",    32'(bus.busy),    32'd0);
        check("abort_bcd_out", 32'(bus.bcd_out), 32'd0);
        tick(5);
        convert(16'd4321, 1, 22);
        check("after_abort", 32'(bus.bcd_out), 32'h04321);

        for (int i = 0; i < 20; i++) begin
            convert(16'($urandom_range(0, 65535)), int'($urandom_range(1, 20)),
                    int'($urandom_range(1, 25)));
        end
        convert(16'd5, 1, 22);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
